// File: rtl/instr_fetch_if.sv
// Fetch-unit bus: decode redirect/freeze, instruction memory port, and the decode output slot.
interface instr_fetch_if;
  logic [31:0] Alt_PC_IN;
  logic        Request_Alt_PC_IN;
  logic        WANT_FREEZE_IN;
  logic [31:0] IMem_Addr_OUT;
  logic        IMem_Req_OUT;
  logic        IMem_Ready_IN;
  logic [31:0] IMem_Data_IN;
  logic        IMem_Valid_IN;
  logic [31:0] Instr1_OUT;
  logic [31:0] Instr_PC_OUT;
  logic [31:0] Instr_PC_Plus4_OUT;
  logic        Instr_Valid_OUT;

  modport master (
    input  Alt_PC_IN, Request_Alt_PC_IN, WANT_FREEZE_IN,
    input  IMem_Ready_IN, IMem_Data_IN, IMem_Valid_IN,
    output IMem_Addr_OUT, IMem_Req_OUT,
    output Instr1_OUT, Instr_PC_OUT, Instr_PC_Plus4_OUT, Instr_Valid_OUT
  );

  modport slave (
    output Alt_PC_IN, Request_Alt_PC_IN, WANT_FREEZE_IN,
    output IMem_Ready_IN, IMem_Data_IN, IMem_Valid_IN,
    input  IMem_Addr_OUT, IMem_Req_OUT,
    input  Instr1_OUT, Instr_PC_OUT, Instr_PC_Plus4_OUT, Instr_Valid_OUT
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: 2-credit request stream, 2-entry response FIFO, redirect with in-flight drop.
// Optional FETCH_PERF_CNT_EN adds fetched/bubble performance counters.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h00400000
) (
  input  logic          CLK,
  input  logic          RESET,
  instr_fetch_if.master bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]   Fetch_Count_OUT,
  output logic [31:0]   Bubble_Count_OUT
`endif
);

  logic [31:0]      fetch_pc;
  logic [1:0]       outst, fifo_cnt, drop_cnt;
  logic [1:0][31:0] fifo_instr, fifo_pc;
  logic             wr_ptr, rd_ptr, started;
  logic [31:0]      instr_q, pc_q, plus4_q;
  logic             valid_q;

  logic             redirect, freeze, pop, req, accept, rsp_live, rsp_keep;
  logic [2:0]       credit_used;
  logic [31:0]      rsp_pc;

  assign redirect = bus.Request_Alt_PC_IN;
  assign freeze   = bus.WANT_FREEZE_IN;
  assign pop      = !redirect && !freeze && (fifo_cnt != 2'd0);

  // The slot freed by a pop on this edge is credited now, so a 1-cycle memory streams without gaps.
  assign credit_used = {1'b0, outst} + {1'b0, fifo_cnt} - {2'b00, pop};
  assign req         = started && !redirect && (credit_used < 3'd2);
  assign accept      = req && bus.IMem_Ready_IN;

  assign rsp_live = bus.IMem_Valid_IN && (outst != 2'd0);
  assign rsp_keep = rsp_live && (drop_cnt == 2'd0) && !redirect;

  // Kept responses are in order and contiguous up to fetch_pc, so the oldest one sits outst words back.
  assign rsp_pc = fetch_pc - {28'd0, outst, 2'b00};

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      fetch_pc <= RESET_PC;
      outst    <= 2'd0;
      fifo_cnt <= 2'd0;
      drop_cnt <= 2'd0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      started  <= 1'b0;
      valid_q  <= 1'b0;
      instr_q  <= '0;
      pc_q     <= '0;
      plus4_q  <= '0;
    end else begin
      started <= 1'b1;
      outst   <= outst + {1'b0, accept} - {1'b0, rsp_live};
      if (redirect) begin
        fetch_pc <= {bus.Alt_PC_IN[31:2], 2'b00};
        drop_cnt <= outst - {1'b0, rsp_live};
        fifo_cnt <= 2'd0;
        wr_ptr   <= 1'b0;
        rd_ptr   <= 1'b0;
        valid_q  <= 1'b0;
        instr_q  <= '0;
        pc_q     <= '0;
        plus4_q  <= '0;
      end else begin
        if (accept) fetch_pc <= fetch_pc + 32'd4;
        if (rsp_live && (drop_cnt != 2'd0)) drop_cnt <= drop_cnt - 2'd1;
        if (rsp_keep) wr_ptr <= ~wr_ptr;
        if (pop) rd_ptr <= ~rd_ptr;
        fifo_cnt <= fifo_cnt + {1'b0, rsp_keep} - {1'b0, pop};
        if (!freeze) begin
          valid_q <= pop;
          instr_q <= pop ? fifo_instr[rd_ptr] : '0;
          pc_q    <= pop ? fifo_pc[rd_ptr] : '0;
          plus4_q <= pop ? fifo_pc[rd_ptr] + 32'd4 : '0;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (rsp_keep) begin
      fifo_instr[wr_ptr] <= bus.IMem_Data_IN;
      fifo_pc[wr_ptr]    <= rsp_pc;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      Fetch_Count_OUT  <= '0;
      Bubble_Count_OUT <= '0;
    end else begin
      if (pop) Fetch_Count_OUT <= Fetch_Count_OUT + 32'd1;
      if (!freeze && (redirect || fifo_cnt == 2'd0)) Bubble_Count_OUT <= Bubble_Count_OUT + 32'd1;
    end
  end
`endif

  assign bus.IMem_Addr_OUT      = fetch_pc;
  assign bus.IMem_Req_OUT       = req;
  assign bus.Instr1_OUT         = instr_q;
  assign bus.Instr_PC_OUT       = pc_q;
  assign bus.Instr_PC_Plus4_OUT = plus4_q;
  assign bus.Instr_Valid_OUT    = valid_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: in-order memory model, PC scoreboard, redirect vector table, directed corners.
module tb_instr_fetch;
  localparam logic [31:0] RST_PC = 32'h00400000;

  logic CLK, RESET;
  instr_fetch_if bus();
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt, bubble_cnt;
`endif

  instr_fetch #(.RESET_PC(RST_PC)) dut (
    .CLK(CLK),
    .RESET(RESET),
    .bus(bus)
`ifdef FETCH_PERF_CNT_EN
    ,
    .Fetch_Count_OUT(fetch_cnt),
    .Bubble_Count_OUT(bubble_cnt)
`endif
  );

  typedef struct { logic [31:0] addr; int due; } mem_ent_t;
  typedef struct { logic valid; logic [31:0] pc; } out_t;
  typedef struct {
    logic [31:0] alt;
    logic        frz;
    int          lat;
    logic [31:0] exp_pc;
    logic [31:0] exp_p4;
  } redir_vec_t;

  mem_ent_t    mem_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] exp_pc;
  out_t        last_exp;
  redir_vec_t  vt[5];
  int          cyc, lat_cur, n_vec, n_err;
  logic        pre_req;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5C3_0F1E;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic check_out(input out_t e);
    chk("out_valid", {31'd0, bus.Instr_Valid_OUT}, {31'd0, e.valid});
    chk("out_pc",    bus.Instr_PC_OUT,       e.valid ? e.pc : 32'd0);
    chk("out_plus4", bus.Instr_PC_Plus4_OUT, e.valid ? e.pc + 32'd4 : 32'd0);
    chk("out_instr", bus.Instr1_OUT,         e.valid ? mem_word(e.pc) : 32'd0);
  endtask

  // One clock: sample pre-edge handshake, update scoreboard after the edge, drive memory at negedge.
  task automatic step();
    logic        acc, rd, frz;
    logic [31:0] a, alt;
    #1;
    acc     = bus.IMem_Req_OUT && bus.IMem_Ready_IN;
    a       = bus.IMem_Addr_OUT;
    rd      = bus.Request_Alt_PC_IN;
    alt     = bus.Alt_PC_IN;
    frz     = bus.WANT_FREEZE_IN;
    pre_req = bus.IMem_Req_OUT;
    if (rd) chk("req_in_redirect", {31'd0, pre_req}, 32'd0);
    @(posedge CLK);
    cyc++;
    #1;
    if (acc) begin
      chk("fetch_addr", a, exp_pc);
      mem_q.push_back('{addr: a, due: cyc + lat_cur});
      exp_q.push_back(exp_pc);
      exp_pc = exp_pc + 32'd4;
    end
    if (rd) begin
      exp_q.delete();
      exp_pc   = {alt[31:2], 2'b00};
      last_exp = '{valid: 1'b0, pc: 32'd0};
    end else if (!frz) begin
      if (bus.Instr_Valid_OUT) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_instr: got pc %h, want no instruction", bus.Instr_PC_OUT);
          last_exp = '{valid: 1'b1, pc: bus.Instr_PC_OUT};
        end else begin
          last_exp = '{valid: 1'b1, pc: exp_q.pop_front()};
        end
      end else begin
        last_exp = '{valid: 1'b0, pc: 32'd0};
      end
    end
    check_out(last_exp);
    @(negedge CLK);
    if (mem_q.size() != 0 && mem_q[0].due <= cyc + 1) begin
      bus.IMem_Valid_IN = 1'b1;
      bus.IMem_Data_IN  = mem_word(mem_q[0].addr);
      void'(mem_q.pop_front());
    end else begin
      bus.IMem_Valid_IN = 1'b0;
      bus.IMem_Data_IN  = $urandom;
    end
  endtask

  // Async reset mid-cycle; on release a stale response is presented with nothing outstanding.
  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    chk("rst_req",   {31'd0, bus.IMem_Req_OUT},    32'd0);
    chk("rst_valid", {31'd0, bus.Instr_Valid_OUT}, 32'd0);
    chk("rst_addr",  bus.IMem_Addr_OUT,            RST_PC);
    chk("rst_pc",    bus.Instr_PC_OUT,             32'd0);
    chk("rst_plus4", bus.Instr_PC_Plus4_OUT,       32'd0);
    chk("rst_instr", bus.Instr1_OUT,               32'd0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b1;
    mem_q.delete();
    exp_q.delete();
    exp_pc   = RST_PC;
    last_exp = '{valid: 1'b0, pc: 32'd0};
    bus.IMem_Valid_IN = 1'b1;
    bus.IMem_Data_IN  = 32'hDEADBEEF;
    #1;
    chk("req_release_cycle", {31'd0, bus.IMem_Req_OUT}, 32'd0);
  endtask

  task automatic wait_valid(input string nm, input int budget);
    int n;
    n = 0;
    step();
    while (!bus.Instr_Valid_OUT && n < budget) begin
      step();
      n++;
    end
    if (!bus.Instr_Valid_OUT) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: got no valid instruction, want one within %0d cycles", nm, budget);
    end
  endtask

  initial begin
    vt[0] = '{alt: 32'h00400100, frz: 1'b0, lat: 3, exp_pc: 32'h00400100, exp_p4: 32'h00400104};
    vt[1] = '{alt: 32'h00400203, frz: 1'b1, lat: 1, exp_pc: 32'h00400200, exp_p4: 32'h00400204};
    vt[2] = '{alt: 32'hFFFFFFFC, frz: 1'b0, lat: 2, exp_pc: 32'hFFFFFFFC, exp_p4: 32'h00000000};
    vt[3] = '{alt: 32'h1234567A, frz: 1'b0, lat: 1, exp_pc: 32'h12345678, exp_p4: 32'h1234567C};
    vt[4] = '{alt: 32'h00400001, frz: 1'b1, lat: 3, exp_pc: 32'h00400000, exp_p4: 32'h00400004};

    n_vec = 0; n_err = 0; cyc = 0; lat_cur = 1;
    RESET = 1'b0;
    bus.Alt_PC_IN = '0; bus.Request_Alt_PC_IN = 1'b0; bus.WANT_FREEZE_IN = 1'b0;
    bus.IMem_Ready_IN = 1'b1; bus.IMem_Data_IN = '0; bus.IMem_Valid_IN = 1'b0;
    exp_pc   = RST_PC;
    last_exp = '{valid: 1'b0, pc: 32'd0};

    // Streaming from reset with a 1-cycle memory
    do_reset();
    step();
    #1 chk("req_first", {31'd0, bus.IMem_Req_OUT}, 32'd1);
    wait_valid("first_fetch", 10);
    chk("flow_pc0", bus.Instr_PC_OUT, 32'h00400000);
    step();
    chk("flow_pc1", bus.Instr_PC_OUT, 32'h00400004);
    chk("flow_v1", {31'd0, bus.Instr_Valid_OUT}, 32'd1);

    // Freeze three cycles while showing 0x00400004
    bus.WANT_FREEZE_IN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("frz_hold_pc", bus.Instr_PC_OUT, 32'h00400004);
      if (i == 1) chk("frz_req_drop", {31'd0, pre_req}, 32'd0);
    end
    bus.WANT_FREEZE_IN = 1'b0;
    step();
    chk("frz_resume_pc", bus.Instr_PC_OUT, 32'h00400008);
    chk("frz_resume_v", {31'd0, bus.Instr_Valid_OUT}, 32'd1);
    step();
    chk("frz_next_pc", bus.Instr_PC_OUT, 32'h0040000C);

    // Redirect vector table
    foreach (vt[k]) begin
      lat_cur = vt[k].lat;
      repeat (4) step();
      bus.Request_Alt_PC_IN = 1'b1;
      bus.Alt_PC_IN         = vt[k].alt;
      bus.WANT_FREEZE_IN    = vt[k].frz;
      step();
      chk("redir_bubble_v", {31'd0, bus.Instr_Valid_OUT}, 32'd0);
      chk("redir_bubble_pc", bus.Instr_PC_OUT, 32'd0);
      bus.Request_Alt_PC_IN = 1'b0;
      bus.WANT_FREEZE_IN    = 1'b0;
      #1 chk("redir_next_addr", bus.IMem_Addr_OUT, vt[k].exp_pc);
      wait_valid("redir_target", 20);
      chk("redir_pc",    bus.Instr_PC_OUT,       vt[k].exp_pc);
      chk("redir_plus4", bus.Instr_PC_Plus4_OUT, vt[k].exp_p4);
      chk("redir_instr", bus.Instr1_OUT,         mem_word(vt[k].exp_pc));
    end

    // Random ready / latency / freeze / redirect mix
    for (int i = 0; i < 400; i++) begin
      lat_cur               = $urandom_range(1, 3);
      bus.IMem_Ready_IN     = ($urandom_range(0, 9) < 7);
      bus.WANT_FREEZE_IN    = ($urandom_range(0, 3) == 0);
      bus.Request_Alt_PC_IN = ($urandom_range(0, 24) == 0);
      bus.Alt_PC_IN         = $urandom;
      step();
    end
    bus.Request_Alt_PC_IN = 1'b0;
    bus.WANT_FREEZE_IN    = 1'b0;
    bus.IMem_Ready_IN     = 1'b1;

    // Reset with requests in flight
    lat_cur = 3;
    repeat (3) step();
`ifdef FETCH_PERF_CNT_EN
    bus.WANT_FREEZE_IN = 1'b1;
`endif
    do_reset();
    lat_cur = 1;
`ifdef FETCH_PERF_CNT_EN
    chk("perf_rst_fetch", fetch_cnt, 32'd0);
    chk("perf_rst_bubble", bubble_cnt, 32'd0);
    repeat (6) step();
    bus.IMem_Ready_IN = 1'b0; bus.WANT_FREEZE_IN = 1'b0;
    repeat (2) step();
    bus.IMem_Ready_IN = 1'b1; bus.WANT_FREEZE_IN = 1'b1;
    repeat (6) step();
    bus.IMem_Ready_IN = 1'b0; bus.WANT_FREEZE_IN = 1'b0;
    repeat (2) step();
    bus.IMem_Ready_IN = 1'b1; bus.WANT_FREEZE_IN = 1'b1;
    step();
    bus.IMem_Ready_IN = 1'b0;
    repeat (3) step();
    bus.WANT_FREEZE_IN = 1'b0;
    step();
    repeat (2) step();
    chk("perf_fetch", fetch_cnt, 32'd5);
    chk("perf_bubble", bubble_cnt, 32'd2);
`else
    wait_valid("post_reset", 10);
    chk("post_reset_pc", bus.Instr_PC_OUT, RST_PC);
`endif

    // Drain everything still expected
    bus.WANT_FREEZE_IN    = 1'b0;
    bus.Request_Alt_PC_IN = 1'b0;
    bus.IMem_Ready_IN     = 1'b0;
    for (int i = 0; i < 30 && (exp_q.size() != 0 || mem_q.size() != 0); i++) step();
    chk("drain_left", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
